// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates two writeback requesters (A = ALU, B = load unit) onto the single
// write port of a register file. Contention is resolved round robin. The
// granted write is registered and presented to the register file one cycle
// after the handshake.
//
// Ports
//   clk            single clock, all state updates on posedge
//   rst            asynchronous, active-high reset
//   a_valid/a_reg/a_data/a_ready   requester A handshake and payload
//   b_valid/b_reg/b_data/b_ready   requester B handshake and payload
//   hold           freezes arbitration (no ready, no grant) while high
//   reg_write      registered write enable to the register file
//   write_register registered destination index
//   write_data     registered write data
//   last_grant     0 = A granted most recently (or nothing yet), 1 = B
//   write_count    saturating count of issued writes
// ----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_reg,
    input  logic [size-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_reg,
    input  logic [size-1:0] b_data,
    output logic            b_ready,
    input  logic            hold,
    output logic            reg_write,
    output logic [4:0]      write_register,
    output logic [size-1:0] write_data,
    output logic            last_grant,
    output logic [15:0]     write_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAST_A = 2'd1;
    localparam logic [1:0] LAST_B = 2'd2;

    logic [1:0]      r_state;
    logic            r_reg_write;
    logic [4:0]      r_write_register;
    logic [size-1:0] r_write_data;
    logic [15:0]     r_write_count;

    logic            w_enable;
    logic            w_grant_a;
    logic            w_grant_b;

    // Readiness is a function of valid, hold and state only. rst is folded in
    // so that nothing is accepted while the block is held in reset.
    assign w_enable  = !rst && !hold;
    // A wins unless B is also asking and A was served last.
    assign w_grant_a = w_enable && a_valid && (!b_valid || (r_state != LAST_A));
    assign w_grant_b = w_enable && b_valid && (!a_valid || (r_state == LAST_A));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_reg_write      <= 1'b0;
            r_write_register <= 5'd0;
            r_write_data     <= '0;
            r_write_count    <= 16'd0;
        end else begin
            r_reg_write <= w_grant_a || w_grant_b;
            if (w_grant_a) begin
                r_state          <= LAST_A;
                r_write_register <= a_reg;
                r_write_data     <= a_data;
            end else if (w_grant_b) begin
                r_state          <= LAST_B;
                r_write_register <= b_reg;
                r_write_data     <= b_data;
            end
            if ((w_grant_a || w_grant_b) && (r_write_count != 16'hFFFF)) begin
                r_write_count <= r_write_count + 16'd1;
            end
        end
    end

    assign a_ready        = w_grant_a;
    assign b_ready        = w_grant_b;
    assign reg_write      = r_reg_write;
    assign write_register = r_write_register;
    assign write_data     = r_write_data;
    assign last_grant     = (r_state == LAST_B);
    assign write_count    = r_write_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        b_ready;
    logic        hold;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        last_grant;
    logic [15:0] write_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 = IDLE, 1 = LAST_A, 2 = LAST_B
    int          m_state;
    int          m_count;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [36:0] sb_q[$];

    // Register file fed by the DUT write port, committing on negedge.
    logic [31:0] rf [32];

    regfile_write_arbiter #(.size(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .hold(hold),
        .reg_write(reg_write), .write_register(write_register),
        .write_data(write_data), .last_grant(last_grant),
        .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_write) rf[write_register] <= write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_count = 0;
        m_reg   = 5'd0;
        m_data  = 32'd0;
        sb_q.delete();
    endtask

    // One clock of stimulus. Entered and left at posedge+1.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd,
                         input logic h, input bit quiet);
        bit ga, gb;
        logic [36:0] ent;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        hold = h;
        #2;
        ga = !h && av && (!bv || m_state != 1);
        gb = !h && bv && !ga;
        if (!quiet) begin
            check("a_ready", {31'd0, a_ready}, {31'd0, ga});
            check("b_ready", {31'd0, b_ready}, {31'd0, gb});
        end
        if (ga) begin
            sb_q.push_back({ar, ad});
            m_state = 1;
        end else if (gb) begin
            sb_q.push_back({br, bd});
            m_state = 2;
        end
        if ((ga || gb) && m_count != 65535) m_count++;
        @(posedge clk);
        #1;
        if (ga || gb) begin
            ent    = sb_q.pop_front();
            m_reg  = ent[36:32];
            m_data = ent[31:0];
        end
        if (!quiet) begin
            check("reg_write", {31'd0, reg_write}, {31'd0, (ga || gb)});
            check("write_register", {27'd0, write_register}, {27'd0, m_reg});
            check("write_data", write_data, m_data);
            check("last_grant", {31'd0, last_grant}, (m_state == 2) ? 32'd1 : 32'd0);
            check("write_count", {16'd0, write_count}, m_count);
            $display("t=%0t av=%b bv=%b hold=%b grant=%s reg=%0d data=%h count=%0d",
                     $time, av, bv, h, ga ? "A" : (gb ? "B" : "-"),
                     write_register, write_data, write_count);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reg_write"}, {31'd0, reg_write}, 32'd0);
        check({tag, "_write_register"}, {27'd0, write_register}, 32'd0);
        check({tag, "_write_data"}, write_data, 32'd0);
        check({tag, "_write_count"}, {16'd0, write_count}, 32'd0);
        check({tag, "_last_grant"}, {31'd0, last_grant}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        model_reset();
        rst = 1'b1;
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h1111_1111;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h2222_2222;
        hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Requests are ignored while reset is held.
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Single A write after reset.
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // Asynchronous reset pulse while reg_write is high.
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        #1 rst = 1'b0;
        model_reset();

        // Both requesting from IDLE: A, B, A, B.
        cycle(1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd2, 32'hB000_0002, 1'b0, 1'b0);
        cycle(1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd2, 32'hB000_0002, 1'b0, 1'b0);
        cycle(1'b1, 5'd3, 32'hA000_0003, 1'b1, 5'd4, 32'hB000_0004, 1'b0, 1'b0);
        cycle(1'b1, 5'd3, 32'hA000_0003, 1'b1, 5'd4, 32'hB000_0004, 1'b0, 1'b0);
        check("rr_count4", {16'd0, write_count}, 32'd4);
        check("rr_last_b", {31'd0, last_grant}, 32'd1);

        // Hold for three cycles, then release: state is LAST_B so A goes.
        repeat (3) cycle(1'b1, 5'd8, 32'h0000_0808, 1'b1, 5'd9, 32'h0000_0909, 1'b1, 1'b0);
        cycle(1'b1, 5'd8, 32'h0000_0808, 1'b1, 5'd9, 32'h0000_0909, 1'b0, 1'b0);

        // Lone requesters are served regardless of state; idle holds outputs.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0000_0A0A, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h0000_0B0B, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd12, 32'h0000_0C0C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // Same destination from LAST_A: B first, then A; A's value survives.
        cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b0, 1'b0);
        cycle(1'b1, 5'd7, 32'd1, 1'b0, 5'd7, 32'd2, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("rf7_final", rf[7], 32'd1);

        // Index 0 passes through unmodified.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Drive the counter past its ceiling.
        for (int i = 0; i < 65540; i++)
            cycle(1'b1, 5'd13, i, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 5'd14, 32'h0000_0E0E, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("sat_count", {16'd0, write_count}, 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Overall time bound so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
